// File: rtl/buffer_pkg.sv
// Shared definitions for the line-packing read/write buffers.
package buffer_pkg;

   localparam int unsigned FULL_WIDTH_DEF = 512;
   localparam int unsigned WIDTH_DEF      = 64;
   localparam int unsigned ADDR_WIDTH_DEF = 32;
   localparam int unsigned MAX_ELEMS_DEF  = FULL_WIDTH_DEF / WIDTH_DEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      WRITE  = 2'd2,
      FINISH = 2'd3
   } buf_state_e;

   // Bit offset of an element slot inside a packed line.
   function automatic int unsigned slot_offset(input int unsigned slot, input int unsigned width);
      return slot * width;
   endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Control, element-stream and line-write signals of the write buffer.
interface write_buffer_if #(
   parameter int unsigned FULL_WIDTH = 512,
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH = 32
);
   localparam int unsigned MAX_ELEMS = FULL_WIDTH / WIDTH;

   logic                  start;
   logic [7:0]            base;
   logic [15:0]           count;
   logic [ADDR_WIDTH-1:0] line_addr;
   logic                  busy;
   logic                  in_valid;
   logic [WIDTH-1:0]      in_data;
   logic                  in_ready;
   logic                  wvalid;
   logic [FULL_WIDTH-1:0] wdata;
   logic [MAX_ELEMS-1:0]  wmask;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  wready;
   logic                  done;

   modport master (
      output start, base, count, line_addr, in_valid, in_data, wready,
      input  busy, in_ready, wvalid, wdata, wmask, waddr, done
   );

   modport slave (
      input  start, base, count, line_addr, in_valid, in_data, wready,
      output busy, in_ready, wvalid, wdata, wmask, waddr, done
   );
endinterface

// File: rtl/line_pack_reg.sv
// One memory line of element registers plus per-slot valid mask.
module line_pack_reg
   import buffer_pkg::*;
#(
   parameter  int unsigned FULL_WIDTH = FULL_WIDTH_DEF,
   parameter  int unsigned WIDTH      = WIDTH_DEF,
   localparam int unsigned MAX_ELEMS  = FULL_WIDTH / WIDTH,
   localparam int unsigned SLOT_W     = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  we,
   input  logic [SLOT_W-1:0]     slot,
   input  logic [WIDTH-1:0]      din,
   output logic [FULL_WIDTH-1:0] data,
   output logic [MAX_ELEMS-1:0]  mask
);

   // Clear wins over write; unwritten slots stay zero.
   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         data <= '0;
         mask <= '0;
      end else if (we) begin
         data[slot_offset(32'(slot), WIDTH) +: WIDTH] <= din;
         mask[slot]                                   <= 1'b1;
      end
   end

endmodule

// File: rtl/write_buffer.sv
// Packs a stream of elements into masked full-line memory writes.
module write_buffer
   import buffer_pkg::*;
#(
   parameter int unsigned FULL_WIDTH = FULL_WIDTH_DEF,
   parameter int unsigned WIDTH      = WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input logic           clk,
   input logic           rst_n,
   write_buffer_if.slave bus
);

   localparam int unsigned MAX_ELEMS = FULL_WIDTH / WIDTH;
   localparam int unsigned SLOT_W    = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
   localparam int unsigned PTR_W     = SLOT_W + 1;
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_ELEMS - 1);

   buf_state_e            state, state_next;
   logic [PTR_W-1:0]      ptr;
   logic [15:0]           remaining;
   logic [ADDR_WIDTH-1:0] waddr;
   logic                  busy, in_ready, wvalid, done;
   logic                  load, accept, fire;
   logic [FULL_WIDTH-1:0] line_data;
   logic [MAX_ELEMS-1:0]  line_mask;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      accept     = 1'b0;
      fire       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = (bus.count == 16'd0) ? FINISH : FILL;
            end
         end
         FILL: begin
            if (bus.in_valid) begin
               accept = 1'b1;
               if (ptr == LAST_SLOT || remaining == 16'd1) state_next = WRITE;
            end
         end
         WRITE: begin
            if (bus.wready) begin
               fire       = 1'b1;
               state_next = (remaining == 16'd0) ? FINISH : FILL;
            end
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs registered from the upcoming state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         in_ready <= 1'b0;
         wvalid   <= 1'b0;
         done     <= 1'b0;
      end else begin
         busy     <= (state_next != IDLE);
         in_ready <= (state_next == FILL);
         wvalid   <= (state_next == WRITE);
         done     <= (state_next == FINISH);
      end
   end

   // Slot pointer, element countdown and line address.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         remaining <= '0;
         waddr     <= '0;
      end else if (load) begin
         ptr       <= (32'(bus.base) < MAX_ELEMS) ? PTR_W'(bus.base) : '0;
         remaining <= bus.count;
         waddr     <= bus.line_addr;
      end else if (accept) begin
         ptr       <= ptr + PTR_W'(1);
         remaining <= remaining - 16'd1;
      end else if (fire) begin
         ptr       <= '0;
         waddr     <= waddr + ADDR_WIDTH'(1);
      end
   end

   line_pack_reg #(
      .FULL_WIDTH (FULL_WIDTH),
      .WIDTH      (WIDTH)
   ) u_line (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load | fire),
      .we    (accept),
      .slot  (ptr[SLOT_W-1:0]),
      .din   (bus.in_data),
      .data  (line_data),
      .mask  (line_mask)
   );

   assign bus.busy     = busy;
   assign bus.in_ready = in_ready;
   assign bus.wvalid   = wvalid;
   assign bus.done     = done;
   assign bus.wdata    = line_data;
   assign bus.wmask    = line_mask;
   assign bus.waddr    = waddr;

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: random streams against a line-packing model.
module tb_write_buffer;

   localparam int unsigned FW = 512;
   localparam int unsigned W  = 64;
   localparam int unsigned AW = 32;
   localparam int unsigned ME = FW / W;

   typedef struct {
      logic [AW-1:0] addr;
      logic [ME-1:0] mask;
      logic [FW-1:0] data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   initial forever #5 clk = ~clk;

   write_buffer_if #(.FULL_WIDTH(FW), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

   write_buffer #(.FULL_WIDTH(FW), .WIDTH(W), .ADDR_WIDTH(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int pending     = 0;
   int done_seen   = 0;
   int last_hs_cyc = 0;
   int stall_left  = 0;
   bit mon_en      = 1'b0;
   bit stall_arm   = 1'b0;
   bit rand_wready = 1'b0;
   bit stalled_prev = 1'b0;

   wr_t           exp_q[$];
   wr_t           e;
   logic [W-1:0]  els[$];
   logic [FW-1:0] snap_d;
   logic [ME-1:0] snap_m;
   logic [AW-1:0] snap_a;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference: elements land in consecutive slots from the start slot; a line
   // is emitted when its last slot fills or the stream ends.
   task automatic model(input int b, input int cnt, input logic [AW-1:0] a0);
      int  p;
      wr_t w;
      p      = (b < int'(ME)) ? b : 0;
      w.addr = a0;
      w.mask = '0;
      w.data = '0;
      for (int i = 0; i < cnt; i++) begin
         w.data[p*W +: W] = els[i];
         w.mask[p]        = 1'b1;
         p++;
         if (p == int'(ME) || i == cnt - 1) begin
            exp_q.push_back(w);
            w.addr = w.addr + AW'(1);
            w.mask = '0;
            w.data = '0;
            p      = 0;
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},     FW'(bus.busy),     FW'(1'b0));
      chk({tag, "_in_ready"}, FW'(bus.in_ready), FW'(1'b0));
      chk({tag, "_wvalid"},   FW'(bus.wvalid),   FW'(1'b0));
      chk({tag, "_done"},     FW'(bus.done),     FW'(1'b0));
      chk({tag, "_wdata"},    bus.wdata,         FW'(1'b0));
      chk({tag, "_wmask"},    FW'(bus.wmask),    FW'(1'b0));
      chk({tag, "_waddr"},    FW'(bus.waddr),    FW'(1'b0));
   endtask

   // Write-port responder: steady, random, or a 10-cycle stall on the next request.
   initial begin
      bus.wready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0) begin
            bus.wready = 1'b0;
            stall_left--;
         end else if (stall_arm && bus.wvalid) begin
            stall_arm  = 1'b0;
            stall_left = 9;
            bus.wready = 1'b0;
         end else begin
            bus.wready = rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: checks each accepted write, stall stability and done timing.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (bus.wvalid) begin
            chk("in_ready_low_in_write", FW'(bus.in_ready), FW'(1'b0));
            if (stalled_prev) begin
               chk("stall_wdata", bus.wdata,       snap_d);
               chk("stall_wmask", FW'(bus.wmask),  FW'(snap_m));
               chk("stall_waddr", FW'(bus.waddr),  FW'(snap_a));
            end
            if (bus.wready) begin
               stalled_prev = 1'b0;
               last_hs_cyc  = cyc;
               if (exp_q.size() == 0) begin
                  fail("unexpected_write");
               end else begin
                  e = exp_q.pop_front();
                  chk("waddr", FW'(bus.waddr), FW'(e.addr));
                  chk("wmask", FW'(bus.wmask), FW'(e.mask));
                  chk("wdata", bus.wdata,      e.data);
               end
            end else begin
               stalled_prev = 1'b1;
               snap_d       = bus.wdata;
               snap_m       = bus.wmask;
               snap_a       = bus.waddr;
            end
         end else begin
            stalled_prev = 1'b0;
         end
         if (bus.done) begin
            chk("done_timing",    FW'(cyc),          FW'(last_hs_cyc + 1));
            chk("done_expected",  FW'(pending > 0),  FW'(1'b1));
            chk("writes_drained", FW'(exp_q.size()), FW'(1'b0));
            if (pending > 0) pending--;
            done_seen++;
         end
      end
   end

   // Issues one transfer; stop_after >= 0 abandons it after that many elements.
   task automatic send_xfer(input int b, input int cnt, input logic [AW-1:0] a0,
                            input int gapmax, input bit seq, input bit spurious,
                            input int stop_after);
      int d0;
      int t;
      bit acc;
      els.delete();
      for (int i = 0; i < cnt; i++) els.push_back(seq ? W'(i + 1) : {$urandom, $urandom});
      model(b, cnt, a0);
      pending++;
      d0            = done_seen;
      bus.start     = 1'b1;
      bus.base      = 8'(b);
      bus.count     = 16'(cnt);
      bus.line_addr = a0;
      last_hs_cyc   = cyc;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (spurious) begin
         bus.start     = 1'b1;
         bus.base      = 8'd0;
         bus.count     = 16'd1;
         bus.line_addr = AW'(32'hDEAD);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      for (int i = 0; i < cnt; i++) begin
         if (stop_after >= 0 && i >= stop_after) break;
         repeat ($urandom_range(0, 32'(gapmax))) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = els[i];
         t = 0;
         do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
         end while (!acc && t < 300);
         bus.in_valid = 1'b0;
         if (!acc) begin
            fail("element_accept");
            return;
         end
      end
      if (stop_after >= 0) return;
      t = 0;
      while (done_seen == d0 && t < 1000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (done_seen == d0) begin
         fail("done_wait");
         pending = 0;
         exp_q.delete();
         return;
      end
      @(negedge clk);
      chk("busy_after_done", FW'(bus.busy), FW'(1'b0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.base      = '0;
      bus.count     = '0;
      bus.line_addr = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      // Full aligned line with sequential data.
      send_xfer(0, 8, AW'(32'h100), 0, 1'b1, 1'b0, -1);
      // Unaligned start spilling into a second line.
      send_xfer(5, 6, AW'(32'h20), 0, 1'b0, 1'b0, -1);
      // Empty transfer.
      send_xfer(2, 0, AW'(32'h40), 0, 1'b0, 1'b0, -1);
      // Write port stalled for 10 cycles.
      stall_arm = 1'b1;
      send_xfer(0, 8, AW'(32'h55), 0, 1'b0, 1'b0, -1);
      // Gappy input, three lines, ignored start while busy.
      send_xfer(3, 20, AW'(32'h1000), 3, 1'b0, 1'b1, -1);
      // Out-of-range base falls back to slot 0.
      send_xfer(200, 3, AW'(32'h77), 1, 1'b0, 1'b0, -1);
      // Line address wraps.
      send_xfer(6, 4, AW'(32'hFFFF_FFFF), 0, 1'b0, 1'b0, -1);

      // Reset mid-fill discards the partial line.
      send_xfer(0, 8, AW'(32'h300), 0, 1'b0, 1'b0, 3);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_q.delete();
      pending = 0;
      @(negedge clk);
      chk_zero("midreset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_xfer(0, 2, AW'(32'h310), 0, 1'b0, 1'b0, -1);

      // Random transfers with random write backpressure.
      rand_wready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         int b, cnt;
         b   = int'($urandom_range(0, 9));
         cnt = int'($urandom_range(0, 25));
         send_xfer(b, cnt, AW'($urandom), int'($urandom_range(0, 2)), 1'b0,
                   (cnt > 0) && ($urandom_range(0, 1) == 1), -1);
      end

      repeat (5) @(posedge clk);
      #1;
      chk("final_queue_empty", FW'(exp_q.size()), FW'(1'b0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
